// File: rtl/huffman_sched.sv
`default_nettype none
// huffman_sched -- runs one getnum counting frame, then schedules lowest-pair merges (rev 1.0)
module huffman_sched #(
    parameter int NSYM  = 10,
    parameter int NNODE = 19,
    parameter int WW    = 9
) (
    input  logic          Clk_in,
    input  logic          Rst,
    input  logic          Start,
    input  logic [8:0]    FrameLen,
    output logic          GnClr,
    output logic          GnEn,
    input  logic [WW-1:0] Num0,
    input  logic [WW-1:0] Num1,
    input  logic [WW-1:0] Num2,
    input  logic [WW-1:0] Num3,
    input  logic [WW-1:0] Num4,
    input  logic [WW-1:0] Num5,
    input  logic [WW-1:0] Num6,
    input  logic [WW-1:0] Num7,
    input  logic [WW-1:0] Num8,
    input  logic [WW-1:0] Num9,
    output logic          Busy,
    output logic          MergeValid,
    input  logic          MergeReady,
    output logic [4:0]    MergeA,
    output logic [4:0]    MergeB,
    output logic [4:0]    MergeNode,
    output logic [WW-1:0] MergeWeight,
    output logic [3:0]    NumLeaves,
    output logic          Done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_COUNT  = 3'd2,
        S_SETTLE = 3'd3,
        S_LOAD   = 3'd4,
        S_SCAN   = 3'd5,
        S_EMIT   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t            state, state_nxt;
    logic [8:0]        win_cnt;
    logic [WW-1:0]     weight [NNODE];
    logic [NNODE-1:0]  active;
    logic [4:0]        scan_idx;
    logic [4:0]        min1_idx, min2_idx;
    logic [WW-1:0]     min1_w, min2_w;
    logic              min1_ok, min2_ok;
    logic [4:0]        next_node;
    logic [3:0]        num_leaves;

    logic [WW-1:0]     num [NSYM];
    logic [NSYM-1:0]   load_act;
    logic [3:0]        load_cnt;
    logic [WW-1:0]     sum_w;
    logic [WW-1:0]     cur_w;
    logic              cur_act;
    logic [4:0]        last_node;
    logic              start_ok;

    assign num[0] = Num0;
    assign num[1] = Num1;
    assign num[2] = Num2;
    assign num[3] = Num3;
    assign num[4] = Num4;
    assign num[5] = Num5;
    assign num[6] = Num6;
    assign num[7] = Num7;
    assign num[8] = Num8;
    assign num[9] = Num9;

    assign start_ok  = Start && (FrameLen != 9'd0);
    assign sum_w     = min1_w + min2_w;
    assign cur_w     = weight[scan_idx];
    assign cur_act   = active[scan_idx];
    // Index of the internal node created by the final merge of this frame.
    assign last_node = 5'(NSYM) + 5'(num_leaves) - 5'd2;

    always_comb begin
        load_act = '0;
        load_cnt = '0;
        for (int i = 0; i < NSYM; i++) begin
            load_act[i] = (num[i] != '0);
            load_cnt    = load_cnt + 4'(load_act[i]);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_ok) state_nxt = S_CLEAR;
            S_CLEAR:  state_nxt = S_COUNT;
            S_COUNT:  if (win_cnt == 9'd1) state_nxt = S_SETTLE;
            S_SETTLE: state_nxt = S_LOAD;
            S_LOAD:   state_nxt = (load_cnt <= 4'd1) ? S_DONE : S_SCAN;
            S_SCAN:   if (scan_idx == 5'(NNODE - 1)) state_nxt = S_EMIT;
            S_EMIT:   if (MergeReady) state_nxt = (next_node == last_node) ? S_DONE : S_SCAN;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign GnClr       = (state == S_CLEAR);
    assign GnEn        = (state == S_COUNT);
    assign Busy        = (state != S_IDLE) && (state != S_DONE);
    assign Done        = (state == S_DONE);
    assign MergeValid  = (state == S_EMIT);
    assign MergeA      = MergeValid ? min1_idx  : 5'd0;
    assign MergeB      = MergeValid ? min2_idx  : 5'd0;
    assign MergeNode   = MergeValid ? next_node : 5'd0;
    assign MergeWeight = MergeValid ? sum_w     : '0;
    assign NumLeaves   = num_leaves;

    always_ff @(posedge Clk_in) begin
        if (Rst) begin
            state      <= S_IDLE;
            win_cnt    <= '0;
            active     <= '0;
            scan_idx   <= '0;
            min1_idx   <= '0;
            min2_idx   <= '0;
            min1_w     <= '0;
            min2_w     <= '0;
            min1_ok    <= 1'b0;
            min2_ok    <= 1'b0;
            next_node  <= '0;
            num_leaves <= '0;
            for (int i = 0; i < NNODE; i++) weight[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        win_cnt    <= FrameLen;
                        num_leaves <= '0;
                    end
                end
                S_COUNT: win_cnt <= win_cnt - 9'd1;
                S_LOAD: begin
                    for (int i = 0; i < NSYM; i++) begin
                        weight[i] <= num[i];
                        active[i] <= load_act[i];
                    end
                    for (int i = NSYM; i < NNODE; i++) begin
                        weight[i] <= '0;
                        active[i] <= 1'b0;
                    end
                    num_leaves <= load_cnt;
                    next_node  <= 5'(NSYM);
                    scan_idx   <= '0;
                    min1_ok    <= 1'b0;
                    min2_ok    <= 1'b0;
                end
                S_SCAN: begin
                    scan_idx <= scan_idx + 5'd1;
                    // Strict compares in ascending index order make ties favour the lower index.
                    if (cur_act) begin
                        if (!min1_ok || (cur_w < min1_w)) begin
                            min2_idx <= min1_idx;
                            min2_w   <= min1_w;
                            min2_ok  <= min1_ok;
                            min1_idx <= scan_idx;
                            min1_w   <= cur_w;
                            min1_ok  <= 1'b1;
                        end else if (!min2_ok || (cur_w < min2_w)) begin
                            min2_idx <= scan_idx;
                            min2_w   <= cur_w;
                            min2_ok  <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (MergeReady) begin
                        active[min1_idx]  <= 1'b0;
                        active[min2_idx]  <= 1'b0;
                        weight[next_node] <= sum_w;
                        active[next_node] <= 1'b1;
                        next_node         <= next_node + 5'd1;
                        scan_idx          <= '0;
                        min1_ok           <= 1'b0;
                        min2_ok           <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/huffman_sched.md
# huffman_sched

Sequencer for the Huffman front end. It runs one symbol-counting frame on the `getnum` frequency counter: clear, then a count window of programmable length. It then loads the ten 9-bit symbol counts into an internal node table and repeatedly selects the two lowest-weight active nodes. Each selection is emitted as a merge command over a valid/ready handshake to the downstream tree/code builder.

## Interface
Parameters:
- `NSYM`, 10: leaf symbols (values 0-9).
- `NNODE`, 19: table entries, 2*NSYM-1.
- `WW`, 9: weight width.

Ports:
- `Clk_in`, in, 1: single clock; all logic on the rising edge.
- `Rst`, in, 1: reset, synchronous and active-high.
- `Start`, in, 1: frame request, sampled in IDLE only.
- `FrameLen`, in, 9: count-window length in cycles, 1..511. Sampled with `Start`.
- `GnClr`, out, 1: clears the `getnum` counters; drives its `Start`.
- `GnEn`, out, 1: count-window gate for `getnum`.
- `Num0`..`Num9`, in, 9 each: counts from `getnum`.
- `Busy`, out, 1: high from the cycle after `Start` is accepted until `Done`.
- `MergeValid`, out, 1: merge command valid.
- `MergeReady`, in, 1: downstream accept.
- `MergeA`, out, 5: node index of the lowest weight.
- `MergeB`, out, 5: node index of the second-lowest weight.
- `MergeNode`, out, 5: index of the new internal node, 10..18.
- `MergeWeight`, out, 9: weight(A)+weight(B).
- `NumLeaves`, out, 4: count of nonzero symbols; valid from LOAD until the next accepted `Start`.
- `Done`, out, 1: one-cycle end-of-frame pulse.

## Operation
- Node table: 19 entries, each holding a 9-bit weight and an active flag.
  - Entries 0-9 are leaves. Entries 10-18 are internal nodes, allocated in order.
- States and transitions:
  - IDLE: `Start`=1 and `FrameLen`≠0 -> CLEAR. `Start` with `FrameLen`=0 is ignored.
  - CLEAR, 1 cycle: `GnClr`=1 -> COUNT.
  - COUNT: `GnEn`=1 for exactly `FrameLen` cycles, tracked by a 9-bit down-counter -> SETTLE.
  - SETTLE, 1 cycle: lets the last count register -> LOAD.
  - LOAD, 1 cycle:
    - weight[i]=Num_i and active[i]=(Num_i≠0) for i=0..9; entries 10-18 cleared.
    - `NumLeaves` = popcount of active flags.
    - Exits to DONE if `NumLeaves`≤1, otherwise to SCAN.
  - SCAN, fixed 19 cycles: visits index 0..18, one per cycle, tracking min1/min2 over active entries.
    - Strict less-than compare, so ties resolve to the lower index.
    - A node can fill only one of the two slots.
    - Exits to EMIT.
  - EMIT: `MergeValid`=1 with A=min1, B=min2, Node=next internal index, Weight=sum.
    - Outputs are held stable until `MergeReady`=1.
    - On the handshake edge: A and B deactivated; Node written with Weight and activated; next index incremented.
    - Exits to DONE if that was merge `NumLeaves`-1, otherwise back to SCAN.
  - DONE, 1 cycle: `Done`=1, `Busy`=0 -> IDLE.
- Arithmetic: the sum is at most `FrameLen`≤511, so 9 bits never overflow. No saturation is needed.
- `Start` while `Busy` is ignored.
- `Rst` in any state forces IDLE next cycle, with all outputs at reset values. A partially counted frame is abandoned.

## Timing
- Reset values: all outputs 0, including `NumLeaves`, `Merge*`, `GnClr`, `GnEn`, `Busy`, `Done`.
- Frame timeline, with `Start` accepted at edge k and F = `FrameLen`:

| Cycle(s) | Event |
|---|---|
| k+1 | `GnClr`=1 |
| k+2 .. k+1+F | `GnEn`=1 |
| k+2+F | SETTLE |
| k+3+F | LOAD |
| k+4+F .. k+22+F | SCAN |
| k+23+F | first `MergeValid` |

- Once `MergeValid` is high it stays high until the handshake.
- The next `MergeValid` is asserted 20 cycles after the handshake cycle, at the earliest.
- `Done` rises the cycle after the final handshake, or the cycle after LOAD when `NumLeaves`≤1.
- `Busy` is high from k+1 through the cycle before `Done`.
- Up to 9 merges per frame; exactly `NumLeaves`-1 are emitted.

## Test plan
- F=6, data 3,3,3,1,1,7 (counts n3=3, n1=2, n7=1), `MergeReady` tied 1:
  - Merge 1: A=7, B=1, Node=10, W=3.
  - Merge 2: A=3, B=10, Node=11, W=6 (tie resolved to lower index).
  - `NumLeaves`=3, `Done` pulse.
- F=4, all data 5 -> `NumLeaves`=1, no `MergeValid`, `Done` at k+4+F.
- `MergeReady` held 0 for 50 cycles during merge 1 -> `MergeValid` and fields stable throughout. One merge is emitted on release.
- F=10, data 0..9 once each -> 9 merges.
  - First merge: A=0, B=1, W=2.
  - Final merge: W=10, Node=18.
- `Rst` pulsed in COUNT, then in EMIT -> next cycle all outputs 0 and state IDLE. A new `Start` then runs a clean frame.
- `Start` with F=0, and `Start` re-asserted while `Busy` -> both ignored, with no `GnClr` pulse from either.
